// File: rtl/micro_sequencer_if.sv
// ============================================================================
// Module   : micro_sequencer_if
// Purpose  : Datapath flags, table-configuration port and control outputs of
//            the micro-sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface micro_sequencer_if #(
    parameter int CW   = 43,
    parameter int SW   = 7,
    parameter int CNTW = 6
);
    localparam int UW = CW + CNTW + SW + 4;

    logic [5:0]      OPCODE;
    logic [5:0]      FUNCT;
    logic            O;
    logic            DIV0;
    logic            ZERO;
    logic            stall;
    logic            ucfg_we;
    logic [SW-1:0]   ucfg_addr;
    logic [UW-1:0]   ucfg_data;
    logic            dcfg_we;
    logic [6:0]      dcfg_addr;
    logic [SW:0]     dcfg_data;
    logic [CW-1:0]   ctrl_out;
    logic [SW-1:0]   state_out;
    logic [CNTW-1:0] cnt_out;
    logic [1:0]      exc_cause;
    logic            exc_pulse;

    modport master (
        output OPCODE, FUNCT, O, DIV0, ZERO, stall,
        output ucfg_we, ucfg_addr, ucfg_data, dcfg_we, dcfg_addr, dcfg_data,
        input  ctrl_out, state_out, cnt_out, exc_cause, exc_pulse
    );

    modport slave (
        input  OPCODE, FUNCT, O, DIV0, ZERO, stall,
        input  ucfg_we, ucfg_addr, ucfg_data, dcfg_we, dcfg_addr, dcfg_data,
        output ctrl_out, state_out, cnt_out, exc_cause, exc_pulse
    );
endinterface

`default_nettype wire

// File: rtl/micro_sequencer.sv
// ============================================================================
// Module   : micro_sequencer
// Purpose  : Table-driven multicycle control sequencer with dwell counts,
//            flag/opcode dispatch and exception vectoring.
// Revision : 1.0
// ============================================================================
`default_nettype none

module micro_sequencer #(
    parameter int            CW             = 43,
    parameter int            SW             = 7,
    parameter int            CNTW           = 6,
    parameter logic [SW-1:0] EXC_OVF_STATE  = 7'd64,
    parameter logic [SW-1:0] EXC_DIV0_STATE = 7'd65,
    parameter logic [SW-1:0] EXC_OP_STATE   = 7'd66
) (
    input  logic             clk,
    input  logic             reset_in,
    micro_sequencer_if.slave bus
);
    localparam int NSTATES = 2**SW;
    localparam int UW      = CW + CNTW + SW + 4;
    localparam int DKEYS   = 128;

    typedef enum logic [1:0] {
        MODE_JUMP     = 2'b00,
        MODE_SEQ      = 2'b01,
        MODE_DISPATCH = 2'b10,
        MODE_BRANCH   = 2'b11
    } mode_e;

    logic [UW-1:0]   utab_w [NSTATES];
    logic [SW:0]     dtab_w [DKEYS];

    logic [SW-1:0]   state_q, state_d;
    logic [CNTW-1:0] cnt_q,   cnt_d;
    logic [1:0]      cause_q, cause_d;
    logic            pulse_q, pulse_d;

    // One register per table entry so reset can clear every entry at once.
    generate
        for (genvar i = 0; i < NSTATES; i++) begin : g_utab
            logic [UW-1:0] entry_q;
            always_ff @(posedge clk or negedge reset_in) begin
                if (!reset_in)
                    entry_q <= '0;
                else if (bus.ucfg_we && (bus.ucfg_addr == SW'(i)))
                    entry_q <= bus.ucfg_data;
            end
            assign utab_w[i] = entry_q;
        end

        for (genvar k = 0; k < DKEYS; k++) begin : g_dtab
            logic [SW:0] entry_q;
            always_ff @(posedge clk or negedge reset_in) begin
                if (!reset_in)
                    entry_q <= '0;
                else if (bus.dcfg_we && (bus.dcfg_addr == 7'(k)))
                    entry_q <= bus.dcfg_data;
            end
            assign dtab_w[k] = entry_q;
        end
    endgenerate

    logic [UW-1:0]   word_w;
    logic [CW-1:0]   ctrl_w;
    logic [CNTW-1:0] dwell_w;
    logic [SW-1:0]   target_w;
    mode_e           mode_w;
    logic            chk_ovf_w;
    logic            chk_div0_w;
    logic [6:0]      key_w;
    logic [SW:0]     dent_w;

    assign word_w     = utab_w[state_q];
    assign ctrl_w     = word_w[CW-1:0];
    assign dwell_w    = word_w[CW +: CNTW];
    assign target_w   = word_w[CW+CNTW +: SW];
    assign mode_w     = mode_e'(word_w[CW+CNTW+SW +: 2]);
    assign chk_ovf_w  = word_w[UW-2];
    assign chk_div0_w = word_w[UW-1];

    // R-type instructions (opcode 0) dispatch on funct in the upper half.
    assign key_w  = (bus.OPCODE == 6'd0) ? {1'b1, bus.FUNCT} : {1'b0, bus.OPCODE};
    assign dent_w = dtab_w[key_w];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        pulse_d = 1'b0;
        if (!bus.stall) begin
            if (cnt_q < dwell_w) begin
                cnt_d = cnt_q + CNTW'(1);
            end else begin
                cnt_d = '0;
                if (chk_ovf_w && bus.O) begin
                    state_d = EXC_OVF_STATE;
                    cause_d = 2'd1;
                    pulse_d = 1'b1;
                end else if (chk_div0_w && bus.DIV0) begin
                    state_d = EXC_DIV0_STATE;
                    cause_d = 2'd2;
                    pulse_d = 1'b1;
                end else begin
                    case (mode_w)
                        MODE_JUMP:   state_d = target_w;
                        MODE_SEQ:    state_d = state_q + SW'(1);
                        MODE_DISPATCH: begin
                            if (dent_w[SW]) begin
                                state_d = dent_w[SW-1:0];
                            end else begin
                                state_d = EXC_OP_STATE;
                                cause_d = 2'd3;
                                pulse_d = 1'b1;
                            end
                        end
                        MODE_BRANCH: state_d = bus.ZERO ? target_w : state_q + SW'(1);
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state_q <= '0;
            cnt_q   <= '0;
            cause_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
            pulse_q <= pulse_d;
        end
    end

    assign bus.ctrl_out  = ctrl_w;
    assign bus.state_out = state_q;
    assign bus.cnt_out   = cnt_q;
    assign bus.exc_cause = cause_q;
    assign bus.exc_pulse = pulse_q;

endmodule

`default_nettype wire

// File: tb/tb_micro_sequencer.sv
// ============================================================================
// Module   : tb_micro_sequencer
// Purpose  : Self-checking bench for micro_sequencer: directed scenarios and
//            randomized traffic against a behavioural sequencer model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_micro_sequencer;
    logic clk = 1'b0;
    logic reset_in = 1'b0;

    micro_sequencer_if #(.CW(43), .SW(7), .CNTW(6)) bus ();

    micro_sequencer dut (
        .clk      (clk),
        .reset_in (reset_in),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: tables plus sequencer registers as plain integers.
    logic [59:0] m_utab [128];
    logic [7:0]  m_dtab [128];
    int          m_state, m_cnt, m_cause;
    bit          m_pulse;

    function automatic logic [59:0] mw(input bit cd, input bit co, input int mode,
                                       input int tgt, input int dw, input logic [42:0] ctrl);
        return {cd, co, 2'(mode), 7'(tgt), 6'(dw), ctrl};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 128; i++) begin
            m_utab[i] = '0;
            m_dtab[i] = '0;
        end
        m_state = 0; m_cnt = 0; m_cause = 0; m_pulse = 0;
    endtask

    // Advances the model across one rising edge using the current inputs.
    task automatic model_edge();
        logic [59:0] w;
        int dwell, mode, tgt, key;
        int nstate = m_state;
        int ncnt   = m_cnt;
        int ncause = m_cause;
        bit npulse = 0;
        w     = m_utab[m_state];
        dwell = int'(w[48:43]);
        tgt   = int'(w[55:49]);
        mode  = int'(w[57:56]);
        if (!bus.stall) begin
            if (m_cnt < dwell) begin
                ncnt = m_cnt + 1;
            end else begin
                ncnt = 0;
                if (w[58] && bus.O) begin
                    nstate = 64; ncause = 1; npulse = 1;
                end else if (w[59] && bus.DIV0) begin
                    nstate = 65; ncause = 2; npulse = 1;
                end else if (mode == 0) begin
                    nstate = tgt;
                end else if (mode == 1) begin
                    nstate = (m_state + 1) % 128;
                end else if (mode == 2) begin
                    key = (bus.OPCODE == 0) ? 64 + int'(bus.FUNCT) : int'(bus.OPCODE);
                    if (m_dtab[key][7]) nstate = int'(m_dtab[key][6:0]);
                    else begin nstate = 66; ncause = 3; npulse = 1; end
                end else begin
                    nstate = bus.ZERO ? tgt : (m_state + 1) % 128;
                end
            end
        end
        if (bus.ucfg_we) m_utab[bus.ucfg_addr] = bus.ucfg_data;
        if (bus.dcfg_we) m_dtab[bus.dcfg_addr] = bus.dcfg_data;
        m_state = nstate; m_cnt = ncnt; m_cause = ncause; m_pulse = npulse;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string step);
        chk({step, ".state"}, 64'(bus.state_out), 64'(m_state));
        chk({step, ".cnt"},   64'(bus.cnt_out),   64'(m_cnt));
        chk({step, ".ctrl"},  64'(bus.ctrl_out),  64'(m_utab[m_state][42:0]));
        chk({step, ".cause"}, 64'(bus.exc_cause), 64'(m_cause));
        chk({step, ".pulse"}, 64'(bus.exc_pulse), 64'(m_pulse));
    endtask

    task automatic expect_sc(input string step, input int s, input int c);
        chk({step, ".exp_state"}, 64'(bus.state_out), 64'(s));
        chk({step, ".exp_cnt"},   64'(bus.cnt_out),   64'(c));
    endtask

    task automatic expect_exc(input string step, input int cause, input int pulse);
        chk({step, ".exp_cause"}, 64'(bus.exc_cause), 64'(cause));
        chk({step, ".exp_pulse"}, 64'(bus.exc_pulse), 64'(pulse));
    endtask

    task automatic tick(input string step);
        model_edge();
        @(posedge clk);
        #1;
        compare_all(step);
    endtask

    task automatic cfg_u(input int addr, input logic [59:0] data);
        bus.ucfg_we = 1'b1; bus.ucfg_addr = 7'(addr); bus.ucfg_data = data;
        tick("cfg_u");
        bus.ucfg_we = 1'b0;
    endtask

    task automatic cfg_d(input int addr, input logic [7:0] data);
        bus.dcfg_we = 1'b1; bus.dcfg_addr = 7'(addr); bus.dcfg_data = data;
        tick("cfg_d");
        bus.dcfg_we = 1'b0;
    endtask

    initial begin
        bus.OPCODE = '0; bus.FUNCT = '0; bus.O = 0; bus.DIV0 = 0; bus.ZERO = 0;
        bus.stall = 0; bus.ucfg_we = 0; bus.ucfg_addr = '0; bus.ucfg_data = '0;
        bus.dcfg_we = 0; bus.dcfg_addr = '0; bus.dcfg_data = '0;
        model_reset();

        // Reset and idle with empty tables.
        repeat (3) @(posedge clk);
        #1;
        compare_all("reset");
        expect_sc("reset", 0, 0);
        chk("reset.ctrl0", 64'(bus.ctrl_out), 64'd0);
        reset_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick("idle");
            expect_sc("idle", 0, 0);
        end

        // Program the directed scenario while parked in state 0.
        cfg_u(1,   mw(0, 0, 1, 0,  2, 43'h1_0000_2001));
        cfg_u(2,   mw(0, 0, 0, 3,  0, 43'h2));
        cfg_u(3,   mw(0, 0, 0, 4,  0, 43'h3));
        cfg_u(4,   mw(0, 0, 2, 0,  0, 43'h4));
        cfg_u(5,   mw(0, 1, 0, 4,  1, 43'h5));
        cfg_u(10,  mw(0, 0, 0, 4,  0, 43'hA));
        cfg_u(64,  mw(0, 0, 0, 4,  0, 43'h40));
        cfg_u(65,  mw(0, 0, 0, 4,  0, 43'h41));
        cfg_u(66,  mw(0, 0, 0, 4,  0, 43'h42));
        cfg_u(127, mw(0, 0, 3, 10, 0, 43'h7F));
        cfg_d(7'h60, {1'b1, 7'd5});
        cfg_d(7'h01, {1'b1, 7'd1});
        cfg_d(7'h02, {1'b1, 7'd127});
        expect_sc("parked", 0, 0);
        cfg_u(0,   mw(0, 0, 0, 1,  0, 43'h0));
        expect_sc("w0", 0, 0);

        // Sequential dwell then jumps.
        tick("p2"); expect_sc("p2a", 1, 0);
        chk("p2.ctrl", 64'(bus.ctrl_out), 64'h1_0000_2001);
        tick("p2"); expect_sc("p2b", 1, 1);
        tick("p2"); expect_sc("p2c", 1, 2);
        tick("p2"); expect_sc("p2d", 2, 0);
        bus.OPCODE = 6'h00; bus.FUNCT = 6'h20;
        tick("p2"); expect_sc("p2e", 3, 0);
        tick("p3"); expect_sc("p3a", 4, 0);

        // Dispatch hit, overflow on non-final cycle, dispatch miss.
        tick("p3"); expect_sc("p3b", 5, 0);
        bus.O = 1;
        tick("p4"); expect_sc("p4a", 5, 1); expect_exc("p4a", 0, 0);
        bus.O = 0;
        tick("p4"); expect_sc("p4b", 4, 0);
        bus.OPCODE = 6'h3F;
        tick("p3"); expect_sc("p3c", 66, 0); expect_exc("p3c", 3, 1);
        tick("p3"); expect_sc("p3d", 4, 0);  expect_exc("p3d", 3, 0);
        bus.OPCODE = 6'h00;
        tick("p4"); expect_sc("p4c", 5, 0);
        tick("p4"); expect_sc("p4d", 5, 1);
        bus.O = 1;
        tick("p4"); expect_sc("p4e", 64, 0); expect_exc("p4e", 1, 1);
        bus.O = 0;
        tick("p4"); expect_sc("p4f", 4, 0);  expect_exc("p4f", 1, 0);
        cfg_u(5, mw(1, 1, 0, 4, 1, 43'h55));
        expect_sc("p4g", 5, 0);
        bus.O = 1; bus.DIV0 = 1;
        tick("p4"); expect_sc("p4h", 5, 1);
        tick("p4"); expect_sc("p4i", 64, 0); expect_exc("p4i", 1, 1);
        bus.O = 0; bus.DIV0 = 0;
        tick("p4"); expect_sc("p4j", 4, 0);

        // Stall inside a dwell-2 state.
        bus.OPCODE = 6'h01;
        tick("p5"); expect_sc("p5a", 1, 0);
        tick("p5"); expect_sc("p5b", 1, 1);
        bus.stall = 1;
        for (int i = 0; i < 4; i++) begin
            tick("p5stall"); expect_sc("p5stall", 1, 1);
        end
        bus.stall = 0;
        tick("p5"); expect_sc("p5c", 1, 2);
        tick("p5"); expect_sc("p5d", 2, 0);

        // Branch taken and not-taken wrap from the last state.
        tick("p6"); expect_sc("p6a", 3, 0);
        bus.OPCODE = 6'h02;
        tick("p6"); expect_sc("p6b", 4, 0);
        tick("p6"); expect_sc("p6c", 127, 0);
        bus.ZERO = 1;
        tick("p6"); expect_sc("p6d", 10, 0);
        bus.ZERO = 0;
        tick("p6"); expect_sc("p6e", 4, 0);
        tick("p6"); expect_sc("p6f", 127, 0);
        tick("p6"); expect_sc("p6g", 0, 0);
        tick("p6"); expect_sc("p6h", 1, 0);

        // Asynchronous reset between edges.
        #2 reset_in = 1'b0;
        model_reset();
        #1;
        expect_sc("arst", 0, 0);
        expect_exc("arst", 0, 0);
        chk("arst.ctrl", 64'(bus.ctrl_out), 64'd0);
        compare_all("arst");
        repeat (2) @(posedge clk);
        #1 reset_in = 1'b1;

        // Randomized traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            logic [63:0] r;
            r = {$urandom, $urandom};
            bus.ucfg_we   = ($urandom_range(0, 5) == 0);
            bus.ucfg_addr = 7'($urandom);
            bus.ucfg_data = mw($urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0,
                               int'($urandom_range(0, 3)), int'($urandom_range(0, 127)),
                               int'($urandom_range(0, 3)), r[42:0]);
            bus.dcfg_we   = ($urandom_range(0, 5) == 0);
            bus.dcfg_addr = 7'($urandom);
            bus.dcfg_data = 8'($urandom);
            bus.OPCODE    = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom);
            bus.FUNCT     = 6'($urandom);
            bus.O         = ($urandom_range(0, 3) == 0);
            bus.DIV0      = ($urandom_range(0, 3) == 0);
            bus.ZERO      = ($urandom_range(0, 1) == 0);
            bus.stall     = ($urandom_range(0, 4) == 0);
            tick("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
